mult_issue_scheduler: RTL and testbench

//  Shares the core's single multi-cycle multiplier between the two superscalar issue lanes.

---
 rtl/mult_issue_scheduler.sv | 106 ++++++++++
 tb/tb_mult_issue_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_scheduler.sv
// Shares one multi-cycle multiplier between the two issue lanes.
// Lane 0 (older) has fixed priority. A 3-bit counter tracks the op:
// 0 = idle, 1..MULT_LATENCY-1 = busy, MULT_LATENCY = result cycle.
// The ALU is stalled one cycle ahead so the two units never write back together.
module mult_issue_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 5,
  parameter int MULT_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [TAG_WIDTH-1:0]  tag0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b1,
  input  logic [TAG_WIDTH-1:0]  tag1,
  input  logic                  flush,
  output logic                  stall_lane0,
  output logic                  stall_lane1,
  output logic                  stall_ALU,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  result_tag,
  output logic                  busy
);

  localparam logic [2:0] CNT_IDLE = 3'd0;
  localparam logic [2:0] CNT_LAST = 3'(MULT_LATENCY - 1);
  localparam logic [2:0] CNT_DONE = 3'(MULT_LATENCY);

  logic [2:0]            count;
  logic [2:0]            count_nxt;
  logic                  flush_pending;
  logic                  flush_pending_nxt;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [TAG_WIDTH-1:0]  op_tag;
  logic [DATA_WIDTH-1:0] product;
  logic                  slot_free;
  logic                  in_flight;
  logic                  accept;

  // Slot availability, lane arbitration, stalls and status outputs.
  always_comb begin
    slot_free    = (count == CNT_IDLE) || (count == CNT_DONE);
    in_flight    = (count != CNT_IDLE) && (count != CNT_DONE);
    accept       = (req0 | req1) & ~flush & slot_free;
    // A flush drops this cycle's requests, so nothing is told to hold.
    stall_lane0  = reset & ~flush & req0 & ~accept;
    stall_lane1  = reset & ~flush & req1 & (req0 | ~accept);
    stall_ALU    = (count == CNT_LAST) & ~flush_pending;
    result_valid = (count == CNT_DONE) & ~flush_pending;
    busy         = in_flight;
    product      = op_a * op_b;
  end

  // Counter and flush bookkeeping for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    count_nxt         = count;
    flush_pending_nxt = flush_pending;
    if (accept) begin
      count_nxt         = 3'd1;
      flush_pending_nxt = 1'b0;
    end else if (count == CNT_DONE) begin
      count_nxt         = CNT_IDLE;
      flush_pending_nxt = 1'b0;
    end else if (in_flight) begin
      count_nxt = count + 3'd1;
      if (flush) flush_pending_nxt = 1'b1;
    end
  end

  // Control state and the result register, synchronously reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      count         <= CNT_IDLE;
      flush_pending <= 1'b0;
      result        <= '0;
      result_tag    <= '0;
    end else begin
      count         <= count_nxt;
      flush_pending <= flush_pending_nxt;
      // Capture only completions that will actually be reported.
      if ((count == CNT_LAST) && !flush_pending_nxt) begin
        result     <= product;
        result_tag <= op_tag;
      end
    end
  end

  // Operand latch for the winning lane.
  always_ff @(posedge clock) begin
    // NOTE: pure datapath registers are not reset; they are always written on accept before use.
    if (accept) begin
      op_a   <= req0 ? a0 : a1;
      op_b   <= req0 ? b0 : b1;
      op_tag <= req0 ? tag0 : tag1;
    end
  end

endmodule

// File: tb/tb_mult_issue_scheduler.sv
// Self-checking bench for mult_issue_scheduler (MULT_LATENCY = 3).
// A timestamp-based model predicts all outputs every cycle; directed
// checks pin literal values from hand-worked scenarios.
module tb_mult_issue_scheduler;

  localparam int DW  = 32;
  localparam int TW  = 5;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, flush = 1'b0;
  logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [TW-1:0] tag0 = '0, tag1 = '0;
  logic          stall_lane0, stall_lane1, stall_ALU, result_valid, busy;
  logic [DW-1:0] result;
  logic [TW-1:0] result_tag;

  int checks = 0;
  int errors = 0;

  mult_issue_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .MULT_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .tag0(tag0),
    .req1(req1), .a1(a1), .b1(b1), .tag1(tag1),
    .flush(flush),
    .stall_lane0(stall_lane0), .stall_lane1(stall_lane1), .stall_ALU(stall_ALU),
    .result_valid(result_valid), .result(result), .result_tag(result_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An op accepted in cycle c is busy for c+1..c+LAT-1 and reports in c+LAT.
  int            cyc = 0;
  bit            model_known = 0;
  bit            m_active = 0;
  bit            m_killed = 0;
  int            m_start = 0;
  logic [DW-1:0] m_prod = '0;
  logic [TW-1:0] m_optag = '0;
  logic [DW-1:0] m_res = '0;
  logic [TW-1:0] m_tag = '0;

  always @(negedge clock) begin
    int age;
    bit e_busy, e_done, e_rv, e_sa, e_s0, e_s1, acc;
    age = cyc - m_start;
    e_busy = m_active && age >= 1 && age <= LAT - 1;
    e_done = m_active && age == LAT;
    e_rv   = e_done && !m_killed;
    e_sa   = m_active && age == LAT - 1 && !m_killed;
    acc    = (req0 || req1) && !flush && (!m_active || e_done);
    e_s0   = reset && !flush && req0 && !acc;
    e_s1   = reset && !flush && req1 && (req0 || !acc);
    if (model_known) begin
      if (e_rv) begin
        m_res = m_prod;
        m_tag = m_optag;
      end
      check("m_result_valid", 64'(result_valid), 64'(e_rv));
      check("m_busy", 64'(busy), 64'(e_busy));
      check("m_stall_ALU", 64'(stall_ALU), 64'(e_sa));
      check("m_stall_lane0", 64'(stall_lane0), 64'(e_s0));
      check("m_stall_lane1", 64'(stall_lane1), 64'(e_s1));
      check("m_result", 64'(result), 64'(m_res));
      check("m_result_tag", 64'(result_tag), 64'(m_tag));
    end
    if (!reset) begin
      model_known = 1;
      m_active = 0;
      m_killed = 0;
      m_res = '0;
      m_tag = '0;
    end else if (model_known) begin
      if (e_busy && flush) m_killed = 1;
      if (e_done) m_active = 0;
      if (acc) begin
        m_active = 1;
        m_killed = 0;
        m_start  = cyc;
        m_prod   = req0 ? a0 * b0 : a1 * b1;
        m_optag  = req0 ? tag0 : tag1;
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    req0 = 1'b1; a0 = a; b0 = b; tag0 = t;
  endtask

  task automatic drive1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    req1 = 1'b1; a1 = a; b1 = b; tag1 = t;
  endtask

  initial begin
    // Reset
    step(); step();
    reset = 1'b1;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(result_tag), 64'd0);

    // Single op: 6*7 tag 4
    step(); drive0(6, 7, 4); #2;
    check("single_c0_stall0", 64'(stall_lane0), 64'd0);
    step(); req0 = 1'b0; #2;
    check("single_c1_busy", 64'(busy), 64'd1);
    step(); #2;
    check("single_c2_stallALU", 64'(stall_ALU), 64'd1);
    step(); #2;
    check("single_c3_valid", 64'(result_valid), 64'd1);
    check("single_c3_result", 64'(result), 64'd42);
    check("single_c3_tag", 64'(result_tag), 64'd4);
    step(); #2;
    check("single_c4_valid", 64'(result_valid), 64'd0);

    // Dual request: lane0 3*5 tag1, lane1 2*9 tag2
    step(); drive0(3, 5, 1); drive1(2, 9, 2); #2;
    check("dual_c0_stall1", 64'(stall_lane1), 64'd1);
    step(); req0 = 1'b0; #2;
    check("dual_c1_stall1", 64'(stall_lane1), 64'd1);
    step(); #2;
    check("dual_c2_stall1", 64'(stall_lane1), 64'd1);
    step(); #2;
    check("dual_c3_result", 64'(result), 64'd15);
    check("dual_c3_tag", 64'(result_tag), 64'd1);
    check("dual_c3_stall1", 64'(stall_lane1), 64'd0);
    step(); req1 = 1'b0;
    step(); step(); #2;
    check("dual_c6_valid", 64'(result_valid), 64'd1);
    check("dual_c6_result", 64'(result), 64'd18);
    check("dual_c6_tag", 64'(result_tag), 64'd2);
    step();

    // Back-to-back on lane 0, ending with a wrapping product
    step(); drive0(10, 11, 3); #2;
    check("b2b_c0_stall0", 64'(stall_lane0), 64'd0);
    step(); #2;
    check("b2b_c1_stall0", 64'(stall_lane0), 64'd1);
    step();
    step(); drive0(12, 13, 6); #2;
    check("b2b_c3_result", 64'(result), 64'd110);
    check("b2b_c3_stall0", 64'(stall_lane0), 64'd0);
    step(); step();
    step(); drive0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 7); #2;
    check("b2b_c6_result", 64'(result), 64'd156);
    check("b2b_c6_valid", 64'(result_valid), 64'd1);
    step(); req0 = 1'b0;
    step();
    step(); #2;
    check("wrap_result", 64'(result), 64'h0000_0001);
    check("wrap_tag", 64'(result_tag), 64'd7);
    step();

    // Flush at cycle 1 of an op
    step(); drive0(4, 5, 3);
    step(); req0 = 1'b0; flush = 1'b1; drive1(8, 8, 1); #2;
    check("flush_c1_stall1", 64'(stall_lane1), 64'd0);
    check("flush_c1_busy", 64'(busy), 64'd1);
    step(); flush = 1'b0; req1 = 1'b0; #2;
    check("flush_c2_stallALU", 64'(stall_ALU), 64'd0);
    step(); drive0(2, 2, 9); #2;
    check("flush_c3_valid", 64'(result_valid), 64'd0);
    check("flush_c3_stall0", 64'(stall_lane0), 64'd0);
    check("flush_c3_hold", 64'(result), 64'd1);
    step(); req0 = 1'b0;
    step();
    step(); #2;
    check("flush_next_result", 64'(result), 64'd4);
    check("flush_next_tag", 64'(result_tag), 64'd9);
    step();

    // Flush while idle blocks acceptance
    step(); drive0(9, 9, 2); flush = 1'b1; #2;
    check("idleflush_stall0", 64'(stall_lane0), 64'd0);
    step(); req0 = 1'b0; flush = 1'b0; #2;
    check("idleflush_busy", 64'(busy), 64'd0);

    // Reset in cycle 2 of an op
    step(); drive0(7, 8, 5);
    step(); req0 = 1'b0;
    step(); reset = 1'b0;
    step(); reset = 1'b1; #2;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_tag", 64'(result_tag), 64'd0);
    check("midrst_stallALU", 64'(stall_ALU), 64'd0);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
